pool_buf_writer: RTL
====================

// Module: pool_buf_writer
// PURPOSE
//  Upstream stage of the BRAM DMA. Accepts pooled conv pixels or FC results as a valid/ready stream.
//  Writes them into the source buffers the DMA reads: sa_data (16 banks x 1024 B) or fc_data (1024 B).
//  On completion it issues one start/nth_conv command to the DMA, then waits for the DMA to finish.
// PARAMETERS
//  DATA_WIDTH  8    pixel/result width
//  CONV1_PIX   196  pixels per channel, layer 0 (14x14 pool out)
//  CONV1_CH    6    channels, layer 0
//  CONV2_PIX   25   pixels per channel, layer 1 (5x5 pool out)
//  CONV2_CH    16   channels, layer 1
//  FC1_LEN     120  results, layer 2
//  FC2_LEN     84   results, layer 3
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   async active-low reset
//  cfg_start_i      in   1   1-cycle pulse; begin a fill, latch cfg_layer_i
//  cfg_layer_i      in   2   0=conv1, 1=conv2, 2=fc1, 3=fc2
//  in_valid_i       in   1   beat valid
//  in_ready_o       out  1   beat ready
//  in_data_i        in   8   pixel/result
//  in_ch_i          in   4   channel of beat (ignored for layers 2/3)
//  sa_data_wren_o   out  1   sa_data buffer write strobe
//  sa_data_wrptr_o  out  14  {ch[3:0], idx[9:0]}
//  sa_data_wdata_o  out  8   write data
//  fc_data_wren_o   out  1   fc_data buffer write strobe
//  fc_data_wrptr_o  out  10  result index
//  fc_data_wdata_o  out  8   write data
//  dma_start_o      out  2   DMA start code (1=conv path, 2=fc path)
//  dma_nth_conv_o   out  2   DMA nth_conv select
//  dma_done_i       in   1   DMA idle flag (high when DMA idle)
//  busy_o           out  1   high whenever FSM != S_IDLE
//  done_o           out  1   1-cycle pulse when DMA transfer completes
//  err_o            out  1   sticky: dropped beat; cleared by cfg_start_i
//  stat_cycles_o    out  16  see CONFIGURATION
// BEHAVIOUR
//  Reset: all outputs 0; FSM=S_IDLE; counters 0. Async reset mid-fill aborts everything, no DMA start.
//  FSM S_IDLE -> S_FILL on cfg_start_i; start pulses outside S_IDLE are ignored.
//  FSM S_FILL -> S_KICK the cycle after the final beat is accepted.
//  FSM S_KICK (1 cycle) -> S_WAIT_BUSY -> (dma_done_i==0) S_WAIT_DONE -> (dma_done_i==1) S_IDLE, with done_o.
//  in_ready_o = 1 only in S_FILL; a beat is taken on in_valid_i & in_ready_o.
//  Writes are registered: strobe, address and data appear exactly 1 cycle after the accepting edge.
//  Conv layers: per-channel counter cnt[ch]; address = {ch, cnt[ch]}; cnt[ch]++.
//   Channel is complete at cnt==PIX; the fill ends when every channel 0..CH-1 is complete.
//   Channels may interleave arbitrarily.
//  FC layers: single counter, fc_data_wrptr_o = cnt; the fill ends at cnt==LEN.
//  Dropped beats (still accepted, no write, err_o<=1):
//   in_ch_i >= CH; a beat to an already-complete channel.
//  In S_KICK: dma_start_o / dma_nth_conv_o per layer: 0->(1,0), 1->(1,1), 2->(2,0), 3->(2,1). Both are 0 in all other states.
//  The final write is issued in the S_KICK cycle, so the buffer is complete before the DMA's first read.
//  Counters are 10 bit; PIX/LEN <= 1023 by construction, so no wrap occurs.
// CONFIGURATION
//  Macro POOL_BUF_WRITER_STATS_EN, compiled in:
//   A 16-bit counter clears on the accepted cfg_start_i and increments every non-IDLE cycle, saturating at 0xFFFF.
//   The value is held in S_IDLE and presented on stat_cycles_o.
//  Macro POOL_BUF_WRITER_STATS_EN, compiled out: stat_cycles_o tied to 0; no counter logic.
// STRUCTURE
//  Package pool_buf_pkg:
//   Layer enum.
//   FSM state enum (S_IDLE, S_FILL, S_KICK, S_WAIT_BUSY, S_WAIT_DONE).
//   DMA start/nth code constants.
//   Per-layer PIX/CH/LEN constants.
//  Sub-module pool_ch_cnt_bank: 16 x 10-bit counters plus complete-mask.
//   Interface: clr, inc, ch, limit; outputs cnt[ch], full[ch], all_full(nch).
// TESTING
//  Layer 0: 6x196 beats, channel-sequential.
//   -> 1176 sa writes; last at wrptr {4'd5,10'd195}.
//   -> dma_start_o=1, nth=0 for 1 cycle; done_o after dma_done_i low->high.
//  Layer 1: 16x25 beats, round-robin channels with random in_valid_i gaps.
//   -> each channel writes idx 0..24 in order; KICK only after ch15 idx24.
//  Layer 2: 120 beats -> fc_data_wrptr_o 0..119; then start=2, nth=0.
//  Layer 3: 84 beats -> start=2, nth=1.
//  Layer 0: beat with ch=7, plus a 197th beat on ch0.
//   -> no write, err_o=1, fill still completes.
//   -> next cfg_start_i clears err_o.
//  Reset mid-fill:
//   rst_n low at beat 50 of layer 2 -> all outputs 0, no start issued.
//   A new layer-3 fill then starts again at wrptr 0.

Source files
------------

// File: rtl/pool_buf_writer_pkg.sv
// Shared types and constants for the pooled-pixel / FC-result buffer writer:
// layer and FSM encodings, DMA command codes and per-layer geometry.
package pool_buf_pkg;

    localparam int MAX_CH = 16;
    localparam int CNT_W  = 10;

    localparam int PIX_CONV1 = 196;
    localparam int CH_CONV1  = 6;
    localparam int PIX_CONV2 = 25;
    localparam int CH_CONV2  = 16;
    localparam int LEN_FC1   = 120;
    localparam int LEN_FC2   = 84;

    typedef enum logic [1:0] {
        L_CONV1 = 2'd0,
        L_CONV2 = 2'd1,
        L_FC1   = 2'd2,
        L_FC2   = 2'd3
    } layer_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_KICK,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_e;

    localparam logic [1:0] DMA_START_CONV = 2'd1;
    localparam logic [1:0] DMA_START_FC   = 2'd2;
    localparam logic [1:0] DMA_NTH_0      = 2'd0;
    localparam logic [1:0] DMA_NTH_1      = 2'd1;

    function automatic logic is_fc_layer(layer_e l);
        return (l == L_FC1) || (l == L_FC2);
    endfunction

    function automatic logic [1:0] dma_start_code(layer_e l);
        return is_fc_layer(l) ? DMA_START_FC : DMA_START_CONV;
    endfunction

    // The second layer of each kind (conv2, fc2) selects the second DMA setting.
    function automatic logic [1:0] dma_nth_code(layer_e l);
        return ((l == L_CONV2) || (l == L_FC2)) ? DMA_NTH_1 : DMA_NTH_0;
    endfunction

endpackage

// File: rtl/pool_buf_writer_if.sv
// Valid/ready beat stream feeding the buffer writer (pixel/result plus channel tag).
interface pool_buf_writer_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic [3:0]            in_ch_i;

    modport master (
        output in_valid_i,
        output in_data_i,
        output in_ch_i,
        input  in_ready_o
    );

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  in_ch_i,
        output in_ready_o
    );

endinterface

// File: rtl/pool_buf_writer_ch_cnt_bank.sv
// Bank of 16 per-channel write counters with completion mask; also flags the
// increment that completes the last outstanding channel.
module pool_ch_cnt_bank
    import pool_buf_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [3:0]       ch,
    input  logic [CNT_W-1:0] limit,
    input  logic [4:0]       nch,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             all_full,
    output logic             last
);

    logic [CNT_W-1:0]  cnt_q [MAX_CH];
    logic [MAX_CH-1:0] full_vec;
    logic [MAX_CH-1:0] ch_mask;
    logic [MAX_CH-1:0] ch_hot;

    always_comb begin
        full_vec = '0;
        ch_mask  = '0;
        ch_hot   = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            full_vec[i] = (cnt_q[i] == limit);
            ch_mask[i]  = (5'(i) < nch);
            ch_hot[i]   = (4'(i) == ch);
        end
    end

    assign cnt      = cnt_q[ch];
    assign full     = full_vec[ch];
    assign all_full = &(full_vec | ~ch_mask);

    // Completing increment: this channel reaches limit and every other active
    // channel is already complete.
    assign last = inc && ((cnt_q[ch] + CNT_W'(1)) == limit)
                      && (&(full_vec | ch_hot | ~ch_mask));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_CH; i++) cnt_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < MAX_CH; i++) cnt_q[i] <= '0;
        end else if (inc) begin
            cnt_q[ch] <= cnt_q[ch] + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pool_buf_writer.sv
// Fills the sa_data / fc_data source buffers from a beat stream, then kicks the DMA
// and waits for it. Optional busy-cycle counter under POOL_BUF_WRITER_STATS_EN.
module pool_buf_writer
    import pool_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CONV1_PIX  = PIX_CONV1,
    parameter int CONV1_CH   = CH_CONV1,
    parameter int CONV2_PIX  = PIX_CONV2,
    parameter int CONV2_CH   = CH_CONV2,
    parameter int FC1_LEN    = LEN_FC1,
    parameter int FC2_LEN    = LEN_FC2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start_i,
    input  logic [1:0]            cfg_layer_i,
    pool_buf_writer_if.slave      in_if,
    output logic                  sa_data_wren_o,
    output logic [13:0]           sa_data_wrptr_o,
    output logic [DATA_WIDTH-1:0] sa_data_wdata_o,
    output logic                  fc_data_wren_o,
    output logic [9:0]            fc_data_wrptr_o,
    output logic [DATA_WIDTH-1:0] fc_data_wdata_o,
    output logic [1:0]            dma_start_o,
    output logic [1:0]            dma_nth_conv_o,
    input  logic                  dma_done_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [15:0]           stat_cycles_o
);

    state_e           state;
    layer_e           layer;
    logic [CNT_W-1:0] limit;
    logic [4:0]       nch;
    logic [CNT_W-1:0] cur_cnt;
    logic             cur_full;
    logic             all_full;
    logic             last;
    logic             fc_mode;
    logic             start_take;
    logic             accept;
    logic             ch_ok;
    logic             wr_ok;
    logic             drop;
    logic [3:0]       beat_ch;

    always_comb begin
        limit = CNT_W'(CONV1_PIX);
        nch   = 5'(CONV1_CH);
        unique case (layer)
            L_CONV1: begin limit = CNT_W'(CONV1_PIX); nch = 5'(CONV1_CH); end
            L_CONV2: begin limit = CNT_W'(CONV2_PIX); nch = 5'(CONV2_CH); end
            L_FC1:   begin limit = CNT_W'(FC1_LEN);   nch = 5'd1;         end
            L_FC2:   begin limit = CNT_W'(FC2_LEN);   nch = 5'd1;         end
        endcase
    end

    // FC layers reuse channel 0 of the bank as their single result counter.
    assign fc_mode          = is_fc_layer(layer);
    assign start_take       = (state == S_IDLE) && cfg_start_i;
    assign in_if.in_ready_o = (state == S_FILL);
    assign accept           = in_if.in_valid_i && (state == S_FILL);
    assign beat_ch          = fc_mode ? 4'd0 : in_if.in_ch_i;
    assign ch_ok            = fc_mode || ({1'b0, in_if.in_ch_i} < nch);
    assign wr_ok            = accept && ch_ok && !cur_full;
    assign drop             = accept && !wr_ok;
    assign busy_o           = (state != S_IDLE);

    pool_ch_cnt_bank u_cnt_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_take),
        .inc      (wr_ok),
        .ch       (beat_ch),
        .limit    (limit),
        .nch      (nch),
        .cnt      (cur_cnt),
        .full     (cur_full),
        .all_full (all_full),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            layer           <= L_CONV1;
            sa_data_wren_o  <= 1'b0;
            sa_data_wrptr_o <= '0;
            sa_data_wdata_o <= '0;
            fc_data_wren_o  <= 1'b0;
            fc_data_wrptr_o <= '0;
            fc_data_wdata_o <= '0;
            dma_start_o     <= '0;
            dma_nth_conv_o  <= '0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
        end else begin
            sa_data_wren_o <= 1'b0;
            fc_data_wren_o <= 1'b0;
            dma_start_o    <= '0;
            dma_nth_conv_o <= '0;
            done_o         <= 1'b0;

            if (wr_ok) begin
                if (fc_mode) begin
                    fc_data_wren_o  <= 1'b1;
                    fc_data_wrptr_o <= cur_cnt;
                    fc_data_wdata_o <= in_if.in_data_i;
                end else begin
                    sa_data_wren_o  <= 1'b1;
                    sa_data_wrptr_o <= {beat_ch, cur_cnt};
                    sa_data_wdata_o <= in_if.in_data_i;
                end
            end
            if (drop) err_o <= 1'b1;

            // The completing beat moves straight to KICK so the last write and the
            // DMA command land in the same cycle.
            case (state)
                S_IDLE: begin
                    if (cfg_start_i) begin
                        layer <= layer_e'(cfg_layer_i);
                        err_o <= 1'b0;
                        state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (last || all_full) begin
                        state          <= S_KICK;
                        dma_start_o    <= dma_start_code(layer);
                        dma_nth_conv_o <= dma_nth_code(layer);
                    end
                end
                S_KICK:      state <= S_WAIT_BUSY;
                S_WAIT_BUSY: if (!dma_done_i) state <= S_WAIT_DONE;
                S_WAIT_DONE: begin
                    if (dma_done_i) begin
                        state  <= S_IDLE;
                        done_o <= 1'b1;
                    end
                end
                default:     state <= S_IDLE;
            endcase
        end
    end

`ifdef POOL_BUF_WRITER_STATS_EN
    logic [15:0] stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (start_take) begin
            stat_q <= '0;
        end else if (busy_o && (stat_q != 16'hFFFF)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_cycles_o = stat_q;
`else
    assign stat_cycles_o = '0;
`endif

endmodule
